fu_cdb_arbiter: RTL

Write-back scheduler between the functional-unit array and the common data bus (CDB). Each FU deposits a finished result (destination physical tag plus 64-bit value) into a private one-entry holding buffer. A round-robin arbiter drains up to NUM_CDB buffers per cycle onto registered CDB lanes. Per-FU back-pressure (`fu_ready`) tells issue logic which FUs may complete a new instruction.

---
 rtl/fu_cdb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter: write-back scheduler between the functional units and the CDB.
// Each FU owns a one-entry holding buffer (tag + value). A round-robin arbiter
// drains up to NUM_CDB occupied buffers per cycle onto registered CDB lanes.
//
// Ports:
//   i_clock      system clock
//   i_reset      synchronous, active-high reset (priority over flush/capture)
//   i_flush      squash: drops buffered results, incoming results and grants
//   i_fu_done    per-FU "result presented" strobe
//   i_fu_t_idx   per-FU destination tag, FU i at [i*PR_W +: PR_W]
//   i_fu_result  per-FU result value, FU i at [i*DATA_W +: DATA_W]
//   o_fu_ready   per-FU buffer can accept a result (combinational from state)
//   o_cdb_valid  per-lane valid (registered)
//   o_cdb_t_idx  per-lane tag (registered)
//   o_cdb_value  per-lane value (registered)
module fu_cdb_arbiter #(
  parameter int unsigned NUM_FU  = 8,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned PR_W    = 6,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic [NUM_FU-1:0]         i_fu_done,
  input  logic [NUM_FU*PR_W-1:0]    i_fu_t_idx,
  input  logic [NUM_FU*DATA_W-1:0]  i_fu_result,
  output logic [NUM_FU-1:0]         o_fu_ready,
  output logic [NUM_CDB-1:0]        o_cdb_valid,
  output logic [NUM_CDB*PR_W-1:0]   o_cdb_t_idx,
  output logic [NUM_CDB*DATA_W-1:0] o_cdb_value
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  // One extra bit so rr_ptr + offset never overflows before the modulo fold.
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_CDB + 1);
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

  // Holding buffers and arbitration state
  logic [NUM_FU-1:0]         r_occ;
  logic [PR_W-1:0]           r_buf_t_idx [NUM_FU];
  logic [DATA_W-1:0]         r_buf_value [NUM_FU];
  logic [PTR_W-1:0]          r_rr_ptr;

  // Registered CDB lanes
  logic [NUM_CDB-1:0]        r_cdb_valid;
  logic [NUM_CDB*PR_W-1:0]   r_cdb_t_idx;
  logic [NUM_CDB*DATA_W-1:0] r_cdb_value;

  // Arbitration results
  logic [NUM_FU-1:0]         w_grant;
  logic [NUM_CDB-1:0]        w_lane_valid;
  logic [NUM_CDB*PR_W-1:0]   w_lane_t_idx;
  logic [NUM_CDB*DATA_W-1:0] w_lane_value;
  logic [PTR_W-1:0]          w_last_grant;
  logic [IDX_W-1:0]          w_scan_idx;
  logic [CNT_W-1:0]          w_grant_cnt;
  logic [NUM_FU-1:0]         w_fu_ready;
  logic [NUM_FU-1:0]         w_capture;

  // Round-robin scan from r_rr_ptr; the j-th occupied buffer found drives lane j.
  always_comb begin
    w_grant      = '0;
    w_lane_valid = '0;
    w_lane_t_idx = '0;
    w_lane_value = '0;
    w_last_grant = r_rr_ptr;
    w_scan_idx   = '0;
    w_grant_cnt  = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      w_scan_idx = IDX_W'(r_rr_ptr) + IDX_W'(k);
      if (w_scan_idx >= IDX_W'(NUM_FU)) begin
        w_scan_idx = w_scan_idx - IDX_W'(NUM_FU);
      end
      if (r_occ[PTR_W'(w_scan_idx)] && (w_grant_cnt < CNT_W'(NUM_CDB))) begin
        w_grant[PTR_W'(w_scan_idx)] = 1'b1;
        for (int unsigned j = 0; j < NUM_CDB; j++) begin
          if (w_grant_cnt == CNT_W'(j)) begin
            w_lane_valid[j]                  = 1'b1;
            w_lane_t_idx[j*PR_W +: PR_W]     = r_buf_t_idx[PTR_W'(w_scan_idx)];
            w_lane_value[j*DATA_W +: DATA_W] = r_buf_value[PTR_W'(w_scan_idx)];
          end
        end
        w_last_grant = PTR_W'(w_scan_idx);
        w_grant_cnt  = w_grant_cnt + CNT_W'(1);
      end
    end
  end

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign w_fu_ready = ~r_occ | w_grant;
  // Done without ready is a protocol error and is simply ignored.
  assign w_capture  = i_fu_done & w_fu_ready;

  // Buffer, pointer and CDB register update
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_occ       <= '0;
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      r_cdb_t_idx <= '0;
      r_cdb_value <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        r_buf_t_idx[i] <= '0;
        r_buf_value[i] <= '0;
      end
    end else if (i_flush) begin
      // Squash everything in flight; rr_ptr is deliberately left alone.
      r_occ       <= '0;
      r_cdb_valid <= '0;
      r_cdb_t_idx <= '0;
      r_cdb_value <= '0;
    end else begin
      r_occ       <= w_capture | (r_occ & ~w_grant);
      r_cdb_valid <= w_lane_valid;
      r_cdb_t_idx <= w_lane_t_idx;
      r_cdb_value <= w_lane_value;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (w_capture[i]) begin
          r_buf_t_idx[i] <= i_fu_t_idx[i*PR_W +: PR_W];
          r_buf_value[i] <= i_fu_result[i*DATA_W +: DATA_W];
        end
      end
      // Next scan starts just past the last FU served; wraps to 0 after NUM_FU-1.
      if (|w_grant) begin
        r_rr_ptr <= (w_last_grant == LAST_FU) ? '0 : (w_last_grant + PTR_W'(1));
      end
    end
  end

  assign o_fu_ready  = w_fu_ready;
  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_t_idx = r_cdb_t_idx;
  assign o_cdb_value = r_cdb_value;

endmodule
